segment_reg_scoreboard: RTL and testbench
=========================================

# segment_reg_scoreboard

Segment register file and segment write scoreboard for the decode stage. It consumes the segment read addresses, the needed flags and the segment-load request that segment address/dependency decode produces. It returns segment base values, and it stalls decode while a needed segment has an older write still in flight. Writeback retires segment loads here, updating the register and clearing the pending entry.

## Interface
Parameters:
- SEG_W, 16, segment register width
- CNT_W, 2, width of per-segment pending-write counter (max 2^CNT_W-1 in flight)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dec_valid  in  1  decode has an instruction presented this cycle
- seg1_needed / seg2_needed / seg3_needed  in  1 each  read port n is used by the instruction
- seg1 / seg2 / seg3  in  3 each  read port n segment address (ES=0, CS=1, SS=2, DS=3, FS=4, GS=5, 6/7 reserved)
- ld_seg  in  1  instruction writes a segment register
- dseg  in  3  destination segment address
- flush  in  1  pipeline flush, discard all in-flight segment writes
- wb_valid  in  1  writeback retires a segment load this cycle
- wb_seg  in  3  retired destination segment
- wb_data  in  SEG_W  retired value
- dec_stall  out  1  hold decode; instruction not accepted
- seg1_data / seg2_data / seg3_data  out  SEG_W each  segment value for read port n
- seg_pending  out  8  bit i = cnt[i] != 0 (registered state)
- cnt_err  out  1  sticky, writeback retired a segment with no pending write

## Operation
- State: seg_reg[0..5] (SEG_W), cnt[0..7] (CNT_W), cnt_err.
- Reset: seg_reg all 0, cnt all 0, cnt_err 0.
  - Outputs in the reset cycle after: seg_pending=0, dec_stall=0 (with flush=0), data ports=0.
- Writes to segment 6/7 are dropped. Reads of 6/7 return 0, and cnt[6]/cnt[7] are never incremented.
- Writeback match: wbm(x) = wb_valid & (wb_seg==x).
- Effective pending: ep(x) = cnt[x] − wbm(x), floored at 0.
- Dependency: dep = (seg1_needed & ep(seg1)!=0) | (seg2_needed & ep(seg2)!=0) | (seg3_needed & ep(seg3)!=0).
- Capacity: full = ld_seg & (dseg<6) & (cnt[dseg]==max) & ~wbm(dseg).
- Stall: dec_stall = flush | (dec_valid & (dep | full)).
- Issue: issue = dec_valid & ~dec_stall. Decode must hold all inputs stable while dec_stall=1.
- Read data (combinational):
  - wbm(segn) true → seg_data = wb_data (bypass).
  - Otherwise → seg_data = seg_reg[segn].
  - Valid regardless of needed flag.
- Counter update per segment x, at the clock edge:
  - inc = issue & ld_seg & (dseg==x) & (x<6).
  - dec = wbm(x) & cnt[x]!=0.
  - cnt[x] += inc − dec; simultaneous inc and dec leaves it unchanged.
- Writeback: seg_reg[wb_seg] <= wb_data when wb_valid & wb_seg<6, even if cnt is 0.
- cnt_err: set when wbm(x) & cnt[x]==0. Stays set until reset; that counter does not underflow.
- flush:
  - All cnt cleared next edge; no increment that cycle.
  - A wb in the same cycle still writes seg_reg and does not set cnt_err.
- Reset dominates flush and wb.

## Timing
- Stall, bypass and read data are combinational from inputs and registered state; no added decode latency.
- A writeback in cycle N releases a dependent instruction in cycle N: that instruction is accepted with bypassed data.
- An issue in cycle N is visible as pending (seg_pending, stall of younger readers) from cycle N+1.
- A load issued in N followed by a dependent read in N+1 stalls until writeback.
- A write to seg_reg in cycle N is readable from the register in N+1.

## Test plan
- Reset, then read seg1=3, seg2=2, seg3=0 with needed=1 → all data 0x0000, dec_stall=0, seg_pending=0x00.
- Issue ld_seg dseg=3 (DS). Next cycle, read seg1=3 with needed → dec_stall=1 and seg_pending=0x08. Then wb_valid, wb_seg=3, wb_data=0x1234 → same cycle dec_stall=0 and seg1_data=0x1234. Next cycle cnt[3]=0.
- Issue three DS loads (CNT_W=2) → seg_pending[3]=1, cnt=3.
  - A 4th DS load → dec_stall=1.
  - Same cycle with wbm(3) → accepted, cnt stays 3.
- Issue ES load while the same-cycle wb retires an older ES load → cnt[0] unchanged. Read of ES not needed (seg*_needed=0) → no stall.
- Two SS loads pending, then flush=1 → dec_stall=1 that cycle, seg_pending=0 next cycle. A later wb_seg=2 → seg_reg written, cnt_err=1.
- wb_seg=6 with wb_data=0xFFFF → a read of 6 returns 0, no cnt change, cnt_err=1. Then rst=1 → cnt_err=0.

Source files
------------

// File: rtl/segment_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// segment_reg_scoreboard
//
// Segment register file plus per-segment write scoreboard for the decode stage.
// Decode presents up to three segment reads and an optional segment load; this
// block returns the segment values (with writeback bypass) and holds decode
// while any needed segment still has an older load in flight. Writeback retires
// segment loads here, updating the register and releasing the pending count.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   dec_valid                 decode presents an instruction this cycle
//   seg{1,2,3}_needed         read port n is used by the instruction
//   seg{1,2,3}                read port n segment address (ES..GS = 0..5)
//   ld_seg, dseg              instruction loads segment dseg
//   flush                     discard every in-flight segment write
//   wb_valid, wb_seg, wb_data writeback retires a segment load
//   dec_stall                 decode held, instruction not accepted
//   seg{1,2,3}_data           segment value for read port n
//   seg_pending               bit i set while segment i has a pending write
//   cnt_err                   sticky: writeback with no pending write
// -----------------------------------------------------------------------------
module segment_reg_scoreboard #(
    parameter int unsigned SEG_W = 16,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic             seg1_needed,
    input  logic             seg2_needed,
    input  logic             seg3_needed,
    input  logic [2:0]       seg1,
    input  logic [2:0]       seg2,
    input  logic [2:0]       seg3,
    input  logic             ld_seg,
    input  logic [2:0]       dseg,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [2:0]       wb_seg,
    input  logic [SEG_W-1:0] wb_data,
    output logic             dec_stall,
    output logic [SEG_W-1:0] seg1_data,
    output logic [SEG_W-1:0] seg2_data,
    output logic [SEG_W-1:0] seg3_data,
    output logic [7:0]       seg_pending,
    output logic             cnt_err
);

    // Addresses 6 and 7 are reserved: never written, read as zero.
    localparam logic [2:0]       NUM_SEG = 3'd6;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // State
    logic [SEG_W-1:0] seg_reg_q [8];
    logic [CNT_W-1:0] cnt_q     [8];
    logic [CNT_W-1:0] cnt_d     [8];
    logic             cnt_err_q;

    // Decode-side views of the three read ports
    logic [2:0]       rd_addr [3];
    logic             rd_need [3];
    logic [SEG_W-1:0] rd_data [3];
    logic [2:0]       rd_dep;

    logic [7:0] wbm;       // one-hot writeback match per segment
    logic [7:0] ep_nz;     // pending count minus this cycle's retire is nonzero
    logic [7:0] cnt_inc;
    logic [7:0] cnt_dec;
    logic       dep;
    logic       full;
    logic       issue;
    logic       cnt_err_set;

    assign rd_addr[0] = seg1;
    assign rd_addr[1] = seg2;
    assign rd_addr[2] = seg3;
    assign rd_need[0] = seg1_needed;
    assign rd_need[1] = seg2_needed;
    assign rd_need[2] = seg3_needed;

    // Writeback match, including reserved segments so a stray retire to 6/7
    // is still caught by cnt_err.
    always_comb begin
        wbm = '0;
        if (wb_valid) begin
            wbm[wb_seg] = 1'b1;
        end
    end

    // A segment is effectively pending unless its only outstanding write is
    // retiring right now; that lets a same-cycle writeback release a reader.
    always_comb begin
        ep_nz = '0;
        for (int x = 0; x < 8; x++) begin
            ep_nz[x] = (cnt_q[x] != '0) && !(wbm[x] && (cnt_q[x] == CNT_W'(1)));
        end
    end

    // Read data with writeback bypass; reserved addresses always return zero.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_data[p] = '0;
            rd_dep[p]  = rd_need[p] && ep_nz[rd_addr[p]];
            if (rd_addr[p] < NUM_SEG) begin
                if (wbm[rd_addr[p]]) begin
                    rd_data[p] = wb_data;
                end else begin
                    rd_data[p] = seg_reg_q[rd_addr[p]];
                end
            end
        end
    end

    assign seg1_data = rd_data[0];
    assign seg2_data = rd_data[1];
    assign seg3_data = rd_data[2];

    // Stall: dependency on an in-flight write, or destination counter full.
    // A full counter that retires this cycle has room for the new load.
    assign dep       = |rd_dep;
    assign full      = ld_seg && (dseg < NUM_SEG) && (cnt_q[dseg] == CNT_MAX) && !wbm[dseg];
    assign dec_stall = flush || (dec_valid && (dep || full));
    assign issue     = dec_valid && !dec_stall;

    // Counter next state
    always_comb begin
        cnt_err_set = 1'b0;
        cnt_inc     = '0;
        cnt_dec     = '0;
        for (int x = 0; x < 8; x++) begin
            cnt_inc[x] = issue && ld_seg && (dseg == 3'(x)) && (x < 6);
            cnt_dec[x] = wbm[x] && (cnt_q[x] != '0);
            cnt_d[x]   = cnt_q[x];
            if (flush) begin
                cnt_d[x] = '0;
            end else if (cnt_inc[x] && !cnt_dec[x]) begin
                cnt_d[x] = cnt_q[x] + CNT_W'(1);
            end else if (cnt_dec[x] && !cnt_inc[x]) begin
                cnt_d[x] = cnt_q[x] - CNT_W'(1);
            end
            // Retire with nothing pending; a flush makes such retires expected.
            if (wbm[x] && (cnt_q[x] == '0) && !flush) begin
                cnt_err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int x = 0; x < 8; x++) begin
                seg_reg_q[x] <= '0;
                cnt_q[x]     <= '0;
            end
            cnt_err_q <= 1'b0;
        end else begin
            if (wb_valid && (wb_seg < NUM_SEG)) begin
                seg_reg_q[wb_seg] <= wb_data;
            end
            for (int x = 0; x < 8; x++) begin
                cnt_q[x] <= cnt_d[x];
            end
            if (cnt_err_set) begin
                cnt_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        seg_pending = '0;
        for (int x = 0; x < 8; x++) begin
            seg_pending[x] = (cnt_q[x] != '0);
        end
    end

    assign cnt_err = cnt_err_q;

endmodule

// File: tb/tb_segment_reg_scoreboard.sv
// Directed, table-driven bench for segment_reg_scoreboard. Each table row is
// one clock cycle: inputs are driven after the falling edge, outputs compared
// 1 ns later, and the rising edge then commits the state.
module tb_segment_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic        dec_valid;
    logic        seg1_needed, seg2_needed, seg3_needed;
    logic [2:0]  seg1, seg2, seg3;
    logic        ld_seg;
    logic [2:0]  dseg;
    logic        flush;
    logic        wb_valid;
    logic [2:0]  wb_seg;
    logic [15:0] wb_data;
    logic        dec_stall;
    logic [15:0] seg1_data, seg2_data, seg3_data;
    logic [7:0]  seg_pending;
    logic        cnt_err;

    int errors = 0;
    int checks = 0;

    segment_reg_scoreboard #(
        .SEG_W(16),
        .CNT_W(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dec_valid  (dec_valid),
        .seg1_needed(seg1_needed),
        .seg2_needed(seg2_needed),
        .seg3_needed(seg3_needed),
        .seg1       (seg1),
        .seg2       (seg2),
        .seg3       (seg3),
        .ld_seg     (ld_seg),
        .dseg       (dseg),
        .flush      (flush),
        .wb_valid   (wb_valid),
        .wb_seg     (wb_seg),
        .wb_data    (wb_data),
        .dec_stall  (dec_stall),
        .seg1_data  (seg1_data),
        .seg2_data  (seg2_data),
        .seg3_data  (seg3_data),
        .seg_pending(seg_pending),
        .cnt_err    (cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        dv;
        logic [2:0]  nd;     // {seg1_needed, seg2_needed, seg3_needed}
        logic [2:0]  s1, s2, s3;
        logic        ld;
        logic [2:0]  dseg;
        logic        fl;
        logic        wbv;
        logic [2:0]  wbs;
        logic [15:0] wbd;
        logic        chk;
        logic        e_stall;
        logic [15:0] e_d1, e_d2, e_d3;
        logic [7:0]  e_pend;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst_v, input logic dv, input logic [2:0] nd,
        input logic [2:0] s1_v, input logic [2:0] s2_v, input logic [2:0] s3_v,
        input logic ld, input logic [2:0] ds, input logic fl,
        input logic wbv, input logic [2:0] wbs, input logic [15:0] wbd,
        input logic chk, input logic st,
        input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3,
        input logic [7:0] pend, input logic err);
        vec_t v;
        v.rst = rst_v; v.dv = dv; v.nd = nd;
        v.s1 = s1_v; v.s2 = s2_v; v.s3 = s3_v;
        v.ld = ld; v.dseg = ds; v.fl = fl;
        v.wbv = wbv; v.wbs = wbs; v.wbd = wbd;
        v.chk = chk; v.e_stall = st;
        v.e_d1 = d1; v.e_d2 = d2; v.e_d3 = d3;
        v.e_pend = pend; v.e_err = err;
        return v;
    endfunction

    task automatic drive(input logic rst_v, input logic dv, input logic [2:0] nd,
                         input logic [2:0] s1_v, input logic [2:0] s2_v,
                         input logic [2:0] s3_v, input logic ld, input logic [2:0] ds,
                         input logic fl, input logic wbv, input logic [2:0] wbs,
                         input logic [15:0] wbd);
        rst = rst_v; dec_valid = dv;
        seg1_needed = nd[2]; seg2_needed = nd[1]; seg3_needed = nd[0];
        seg1 = s1_v; seg2 = s2_v; seg3 = s3_v;
        ld_seg = ld; dseg = ds; flush = fl;
        wb_valid = wbv; wb_seg = wbs; wb_data = wbd;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic st, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3,
                             input logic [7:0] pend, input logic err);
        check({tag, " dec_stall"}, 16'(dec_stall), 16'(st));
        check({tag, " seg1_data"}, seg1_data, d1);
        check({tag, " seg2_data"}, seg2_data, d2);
        check({tag, " seg3_data"}, seg3_data, d3);
        check({tag, " seg_pending"}, 16'(seg_pending), 16'(pend));
        check({tag, " cnt_err"}, 16'(cnt_err), 16'(err));
    endtask

    initial begin
        drive(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);

        // rst dv  nd      s1 s2 s3 ld ds fl wbv wbs wbd       chk st d1       d2       d3       pend   err
        tbl.push_back(mk(0, 1, 3'b111, 3, 2, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0));
        // DS load, then a dependent read stalls until the writeback releases it
        tbl.push_back(mk(0, 1, 3'b000, 3, 2, 0, 1, 3, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(0, 1, 3'b100, 3, 2, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h0000, 8'h08, 0));
        tbl.push_back(mk(0, 1, 3'b100, 3, 2, 0, 0, 0, 0, 1, 3, 16'h1234, 1, 0, 16'h1234, 16'h0000, 16'h0000, 8'h08, 0));
        tbl.push_back(mk(0, 1, 3'b100, 3, 2, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h1234, 16'h0000, 16'h0000, 8'h00, 0));
        // Fill DS counter to 3, 4th load stalls, retire lets it in, counter stays 3
        tbl.push_back(mk(0, 1, 3'b000, 3, 2, 0, 1, 3, 0, 0, 0, 16'h0000, 1, 0, 16'h1234, 16'h0000, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(0, 1, 3'b000, 3, 2, 0, 1, 3, 0, 0, 0, 16'h0000, 1, 0, 16'h1234, 16'h0000, 16'h0000, 8'h08, 0));
        tbl.push_back(mk(0, 1, 3'b000, 3, 2, 0, 1, 3, 0, 0, 0, 16'h0000, 1, 0, 16'h1234, 16'h0000, 16'h0000, 8'h08, 0));
        tbl.push_back(mk(0, 1, 3'b000, 3, 2, 0, 1, 3, 0, 0, 0, 16'h0000, 1, 1, 16'h1234, 16'h0000, 16'h0000, 8'h08, 0));
        tbl.push_back(mk(0, 1, 3'b000, 3, 2, 0, 1, 3, 0, 1, 3, 16'h5678, 1, 0, 16'h5678, 16'h0000, 16'h0000, 8'h08, 0));
        tbl.push_back(mk(0, 1, 3'b000, 3, 2, 0, 1, 3, 0, 0, 0, 16'h0000, 1, 1, 16'h5678, 16'h0000, 16'h0000, 8'h08, 0));
        // Drain the three DS loads
        tbl.push_back(mk(0, 0, 3'b000, 3, 2, 0, 0, 0, 0, 1, 3, 16'h1111, 1, 0, 16'h1111, 16'h0000, 16'h0000, 8'h08, 0));
        tbl.push_back(mk(0, 0, 3'b000, 3, 2, 0, 0, 0, 0, 1, 3, 16'h2222, 1, 0, 16'h2222, 16'h0000, 16'h0000, 8'h08, 0));
        tbl.push_back(mk(0, 0, 3'b000, 3, 2, 0, 0, 0, 0, 1, 3, 16'h3333, 1, 0, 16'h3333, 16'h0000, 16'h0000, 8'h08, 0));
        tbl.push_back(mk(0, 0, 3'b000, 3, 2, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h3333, 16'h0000, 16'h0000, 8'h00, 0));
        // ES load concurrent with retire of an older ES load keeps cnt[0]=1
        tbl.push_back(mk(0, 1, 3'b000, 0, 2, 3, 1, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h3333, 8'h00, 0));
        tbl.push_back(mk(0, 1, 3'b000, 0, 2, 3, 1, 0, 0, 1, 0, 16'hAAAA, 1, 0, 16'hAAAA, 16'h0000, 16'h3333, 8'h01, 0));
        tbl.push_back(mk(0, 1, 3'b000, 0, 2, 3, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'hAAAA, 16'h0000, 16'h3333, 8'h01, 0));
        tbl.push_back(mk(0, 1, 3'b100, 0, 2, 3, 0, 0, 0, 0, 0, 16'h0000, 1, 1, 16'hAAAA, 16'h0000, 16'h3333, 8'h01, 0));
        tbl.push_back(mk(0, 1, 3'b100, 0, 2, 3, 0, 0, 0, 1, 0, 16'hBBBB, 1, 0, 16'hBBBB, 16'h0000, 16'h3333, 8'h01, 0));
        tbl.push_back(mk(0, 0, 3'b000, 0, 2, 3, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'hBBBB, 16'h0000, 16'h3333, 8'h00, 0));
        // Two SS loads then flush; a later SS retire writes and flags cnt_err
        tbl.push_back(mk(0, 1, 3'b000, 0, 2, 3, 1, 2, 0, 0, 0, 16'h0000, 1, 0, 16'hBBBB, 16'h0000, 16'h3333, 8'h00, 0));
        tbl.push_back(mk(0, 1, 3'b000, 0, 2, 3, 1, 2, 0, 0, 0, 16'h0000, 1, 0, 16'hBBBB, 16'h0000, 16'h3333, 8'h04, 0));
        tbl.push_back(mk(0, 1, 3'b000, 0, 2, 3, 1, 2, 1, 0, 0, 16'h0000, 1, 1, 16'hBBBB, 16'h0000, 16'h3333, 8'h04, 0));
        tbl.push_back(mk(0, 0, 3'b000, 0, 2, 3, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'hBBBB, 16'h0000, 16'h3333, 8'h00, 0));
        tbl.push_back(mk(0, 0, 3'b000, 0, 2, 3, 0, 0, 0, 1, 2, 16'hC0DE, 1, 0, 16'hBBBB, 16'hC0DE, 16'h3333, 8'h00, 0));
        tbl.push_back(mk(0, 0, 3'b000, 0, 2, 3, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'hBBBB, 16'hC0DE, 16'h3333, 8'h00, 1));
        tbl.push_back(mk(1, 0, 3'b000, 0, 2, 3, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(0, 0, 3'b000, 3, 2, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0));
        // Reserved segment 6: write dropped, no counting, cnt_err set
        tbl.push_back(mk(0, 0, 3'b000, 0, 2, 3, 0, 0, 0, 1, 6, 16'hFFFF, 1, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(0, 1, 3'b110, 6, 7, 3, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1));
        tbl.push_back(mk(0, 1, 3'b000, 6, 7, 3, 1, 6, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1));
        tbl.push_back(mk(0, 1, 3'b100, 6, 7, 3, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1));
        tbl.push_back(mk(1, 0, 3'b000, 6, 7, 3, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(0, 0, 3'b000, 6, 7, 3, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0));
        // Flush alone stalls; a retire under flush still writes without cnt_err
        tbl.push_back(mk(0, 0, 3'b000, 0, 2, 5, 0, 0, 1, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0));
        tbl.push_back(mk(0, 0, 3'b000, 0, 2, 5, 0, 0, 1, 1, 5, 16'h5555, 1, 1, 16'h0000, 16'h0000, 16'h5555, 8'h00, 0));
        tbl.push_back(mk(0, 0, 3'b000, 0, 2, 5, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h5555, 8'h00, 0));

        // Hand sequence: reset with junk on the inputs, then quiet reset state
        @(negedge clk);
        drive(1, 1, 3'b111, 1, 4, 5, 1, 3, 1, 1, 3, 16'hDEAD);
        @(negedge clk);
        drive(0, 0, 3'b000, 3, 2, 0, 0, 0, 0, 0, 0, 16'h0);
        #1;
        check_all("reset", 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].dv, tbl[i].nd, tbl[i].s1, tbl[i].s2, tbl[i].s3,
                  tbl[i].ld, tbl[i].dseg, tbl[i].fl, tbl[i].wbv, tbl[i].wbs, tbl[i].wbd);
            #1;
            if (tbl[i].chk) begin
                check_all($sformatf("row%0d", i), tbl[i].e_stall, tbl[i].e_d1,
                          tbl[i].e_d2, tbl[i].e_d3, tbl[i].e_pend, tbl[i].e_err);
            end
        end

        // Hand sequence: load distinct values into ES, CS, FS, GS and read
        // them back through every port.
        @(negedge clk); drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0E0E);
        @(negedge clk); drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0C0C);
        @(negedge clk); drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 4, 16'h0F0F);
        @(negedge clk); drive(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 5, 16'h0606);
        @(negedge clk); drive(0, 0, 3'b000, 1, 4, 5, 0, 0, 0, 0, 0, 16'h0);
        #1;
        check_all("mux_a", 0, 16'h0C0C, 16'h0F0F, 16'h0606, 8'h00, 1);
        @(negedge clk); drive(0, 0, 3'b000, 5, 0, 1, 0, 0, 0, 0, 0, 16'h0);
        #1;
        check_all("mux_b", 0, 16'h0606, 16'h0E0E, 16'h0C0C, 8'h00, 1);

        // Hand sequence: reset wins over a concurrent flush, writeback and load
        @(negedge clk); drive(0, 1, 3'b000, 1, 4, 5, 1, 1, 0, 0, 0, 16'h0);
        @(negedge clk); drive(0, 0, 3'b000, 1, 4, 5, 0, 0, 0, 0, 0, 16'h0);
        #1;
        check_all("pend_cs", 0, 16'h0C0C, 16'h0F0F, 16'h0606, 8'h02, 1);
        @(negedge clk); drive(1, 1, 3'b000, 1, 4, 5, 1, 4, 1, 1, 1, 16'h9999);
        @(negedge clk); drive(0, 0, 3'b000, 1, 4, 5, 0, 0, 0, 0, 0, 16'h0);
        #1;
        check_all("rst_dom", 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
